// File: rtl/alu_seq_muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer that drives the
// LEGv8 ALU: function-select codes, status-bit indices, the FSM state
// encoding and the operation select values.
package alu_seq_muldiv_pkg;

  // ALU function select codes (B inversion lives in FS[1])
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_LSL = 5'b10000;

  // Bit positions inside the ALU status word {V,C,N,Z}
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  // Operation select on the op port
  localparam logic OP_MUL  = 1'b0;
  localparam logic OP_UDIV = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_ADD  = 3'd1,
    S_MUL_SHL  = 3'd2,
    S_DIV_STEP = 3'd3,
    S_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle MUL / UDIV sequencer. It owns no arithmetic of its own
// beyond a local shift: every add, subtract and left shift is issued to an
// external 64-bit LEGv8 ALU through alu_A/alu_B/alu_FS/alu_C0, and the
// combinational answer (alu_F, alu_status) is latched back the same cycle.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, op           request pulse (accepted only in IDLE), 0=MUL 1=UDIV
//   opa, opb            multiplicand/dividend, multiplier/divisor
//   busy, done          busy from the cycle after acceptance through done;
//                       done is a one-cycle pulse
//   result_lo/hi        product (hi=0) or quotient/remainder, held after done
//   div_by_zero         UDIV with opb==0, valid with done
//   alu_A/B/FS/C0       ALU operand and function drive
//   alu_F, alu_status   ALU result and {V,C,N,Z} flags
module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status
);

  state_t state, state_nxt;

  // Multiply datapath: running sum, shifted multiplicand, remaining multiplier
  logic [WIDTH-1:0] acc, mcand, mplier;
  // Divide datapath: partial remainder, quotient/dividend shift reg, divisor
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mplier_shr;
  logic [WIDTH-1:0] div_t, rem_nxt, quo_nxt;
  logic             div_ge, div_last;
  logic             status_unused;

  assign mplier_shr = mplier >> 1;

  // Restoring division: shift the next dividend bit into the remainder and
  // try to subtract. Carry out of A + ~B + 1 means no borrow, i.e. t >= D.
  // The dividend's top bit feeds t while quo fills from the bottom.
  assign div_t    = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign div_ge   = alu_status[ST_C];
  assign rem_nxt  = div_ge ? alu_F : div_t;
  assign quo_nxt  = {quo[WIDTH-2:0], div_ge};
  assign div_last = (cnt == CNT_W'(WIDTH - 1));

  // Only the carry flag matters to this sequencer
  assign status_unused = ^{alu_status[ST_V], alu_status[ST_N], alu_status[ST_Z]};

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (opb == '0)        state_nxt = S_DONE;
          else if (op == OP_MUL) state_nxt = opb[0] ? S_MUL_ADD : S_MUL_SHL;
          else                   state_nxt = S_DIV_STEP;
        end
      end
      S_MUL_ADD: state_nxt = S_MUL_SHL;
      S_MUL_SHL: begin
        // Stop at the last set multiplier bit instead of walking all 64
        if (mplier_shr == '0)  state_nxt = S_DONE;
        else if (mplier_shr[0]) state_nxt = S_MUL_ADD;
        else                    state_nxt = S_MUL_SHL;
      end
      S_DIV_STEP: state_nxt = div_last ? S_DONE : S_DIV_STEP;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_FS = FS_AND;
    alu_C0 = 1'b0;
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    case (state)
      S_MUL_ADD: begin
        alu_A  = acc;
        alu_B  = mcand;
        alu_FS = FS_ADD;
      end
      S_MUL_SHL: begin
        alu_A  = mcand;
        alu_B  = WIDTH'(1);
        alu_FS = FS_LSL;
      end
      S_DIV_STEP: begin
        alu_A  = div_t;
        alu_B  = dvs;
        alu_FS = FS_SUB;
        alu_C0 = 1'b1;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  // alu_F is only sampled in the working states; IDLE and DONE never
  // touch the ALU result.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= opa;
              mplier <= opb;
              if (opb == '0) begin
                result_lo <= '0;
                result_hi <= '0;
              end
            end else if (opb == '0) begin
              result_lo   <= '0;
              result_hi   <= opa;
              div_by_zero <= 1'b1;
            end else begin
              rem <= '0;
              quo <= opa;
              dvs <= opb;
              cnt <= '0;
            end
          end
        end
        S_MUL_ADD: acc <= alu_F;
        S_MUL_SHL: begin
          mcand  <= alu_F;
          mplier <= mplier_shr;
          // acc is final once no multiplier bits remain
          if (mplier_shr == '0) begin
            result_lo <= acc;
            result_hi <= '0;
          end
        end
        S_DIV_STEP: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (div_last) begin
            result_lo <= quo_nxt;
            result_hi <= rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [63:0] opa, opb;
  logic        busy, done, div_by_zero;
  logic [63:0] result_lo, result_hi;
  logic [63:0] alu_A, alu_B, alu_F;
  logic [4:0]  alu_FS;
  logic        alu_C0;
  logic [3:0]  alu_status;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_seq_muldiv #(.WIDTH(64), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .opa(opa), .opb(opb), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_C0(alu_C0),
    .alu_F(alu_F), .alu_status(alu_status)
  );

  // Behavioural stand-in for the LEGv8 ALU closing the loop
  logic [63:0] bi;
  logic [64:0] sum;
  logic        alu_c, alu_v;
  always_comb begin
    bi  = alu_FS[1] ? ~alu_B : alu_B;
    sum = {1'b0, alu_A} + {1'b0, bi} + {64'd0, alu_C0};
    case (alu_FS[4:2])
      3'b000:  alu_F = alu_A & bi;
      3'b001:  alu_F = alu_A | bi;
      3'b010:  alu_F = sum[63:0];
      3'b011:  alu_F = alu_A ^ bi;
      3'b100:  alu_F = alu_FS[0] ? (alu_A >> alu_B[5:0]) : (alu_A << alu_B[5:0]);
      default: alu_F = 64'd0;
    endcase
    alu_c = (alu_FS[4:2] == 3'b010) ? sum[64] : 1'b0;
    alu_v = (alu_FS[4:2] == 3'b010) && (alu_A[63] == bi[63]) && (alu_F[63] != alu_A[63]);
    alu_status = {alu_v, alu_c, alu_F[63], (alu_F == 64'd0)};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive a request so it is sampled at the next rising edge (cycle 0);
  // returns #1 into cycle 1.
  task automatic start_op(input logic o, input logic [63:0] a, input logic [63:0] b);
    @(negedge clock);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Step until done, checking busy every cycle and the SUB drive when asked
  task automatic wait_done(input int lat0, input bit chk_div, output int lat);
    int bad_busy = 0;
    int bad_fs   = 0;
    bit to = 0;
    lat = lat0;
    while (done !== 1'b1) begin
      if (busy !== 1'b1) bad_busy++;
      if (chk_div && (alu_FS !== 5'b01010 || alu_C0 !== 1'b1)) bad_fs++;
      if (lat > 200) begin to = 1; break; end
      @(posedge clock); #1;
      lat++;
    end
    if (busy !== 1'b1) bad_busy++;
    chk("done_timeout", 64'(to), 64'd0);
    chk("busy_window", 64'(bad_busy), 64'd0);
    if (chk_div) chk("div_fs_c0", 64'(bad_fs), 64'd0);
  endtask

  // Reference: plain arithmetic plus the cost of visiting each multiplier
  // bit up to the highest set one (one shift each, one add per set bit).
  task automatic model(input logic o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] lo, output logic [63:0] hi,
                       output logic dz, output int lat);
    int m = -1;
    dz = 1'b0;
    if (o == 1'b0) begin
      lo = a * b; hi = 64'd0;
      for (int i = 0; i < 64; i++) if (b[i]) m = i;
      lat = (b == 64'd0) ? 1 : 1 + $countones(b) + m + 1;
    end else if (b == 64'd0) begin
      lo = 64'd0; hi = a; dz = 1'b1; lat = 1;
    end else begin
      lo = a / b; hi = a % b; lat = 65;
    end
  endtask

  typedef struct {
    logic        op;
    logic [63:0] a, b, lo, hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[6];

  task automatic run_checked(input logic o, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] elo, input logic [63:0] ehi,
                             input logic edz, input int elat, input string tag);
    int lat;
    bit is_div;
    is_div = (o == 1'b1) && (b != 64'd0);
    start_op(o, a, b);
    wait_done(1, is_div, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_lo"}, result_lo, elo);
    chk({tag, "_hi"}, result_hi, ehi);
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
    chk({tag, "_held"}, result_lo, elo);
  endtask

  initial begin
    int lat, pulses;
    logic [63:0] elo, ehi, a, b, mask;
    logic edz, o;
    int elat, w;

    reset = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outs", {busy, done, div_by_zero}, 64'd0);
    chk("rst_lo", result_lo, 64'd0);
    chk("rst_hi", result_hi, 64'd0);
    chk("idle_fs", 64'(alu_FS), 64'd0);
    chk("idle_ab", alu_A | alu_B, 64'd0);
    reset = 1'b0;

    vt[0] = '{1'b0, 64'd5, 64'd3, 64'd15, 64'd0, 1'b0, 5};
    vt[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 4};
    vt[2] = '{1'b0, 64'h1234, 64'd0, 64'd0, 64'd0, 1'b0, 1};
    vt[3] = '{1'b1, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65};
    vt[4] = '{1'b1, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 65};
    vt[5] = '{1'b1, 64'd9, 64'd0, 64'd0, 64'd9, 1'b1, 1};

    for (int i = 0; i < 6; i++)
      run_checked(vt[i].op, vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, vt[i].dz, vt[i].lat,
                  $sformatf("vec%0d", i));

    // Idle drive after activity
    chk("idle_fs2", 64'(alu_FS), 64'd0);
    chk("idle_ab2", alu_A | alu_B | 64'(alu_C0), 64'd0);

    // start pulses at cycle 10 and in the DONE cycle are ignored
    start_op(1'b1, 64'd1000, 64'd7);
    repeat (9) @(posedge clock);
    #1;
    op = 1'b0; opa = 64'd3; opb = 64'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(11, 1'b1, lat);
    chk("ign_lat", 64'(lat), 64'd65);
    chk("ign_lo", result_lo, 64'd142);
    chk("ign_hi", result_hi, 64'd6);
    op = 1'b1; opa = 64'd77; opb = 64'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ign_done_start", 64'({busy, done}), 64'd0);
    @(posedge clock); #1;
    chk("ign_still_idle", 64'({busy, done}), 64'd0);
    chk("ign_held", {result_lo[31:0], result_hi[31:0]}, {32'd142, 32'd6});
    chk("ign_dz", 64'(div_by_zero), 64'd0);

    // Reset at cycle 20 of a UDIV aborts with no done pulse
    start_op(1'b1, 64'd500, 64'd9);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_outs", 64'({busy, done, div_by_zero}), 64'd0);
    chk("abort_res", result_lo | result_hi, 64'd0);
    pulses = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_checked(1'b1, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, "post_rst");

    // Randomised operations against the reference model
    for (int n = 0; n < 40; n++) begin
      o = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      w = o ? $urandom_range(1, 63) : $urandom_range(1, 64);
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      b = {$urandom, $urandom} & mask;
      if ($urandom_range(0, 7) == 0) b = 64'd0;
      model(o, a, b, elo, ehi, edz, elat);
      run_checked(o, a, b, elo, ehi, edz, elat, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
